// File: rtl/div9_shared_arbiter.sv
// Round-robin arbiter feeding a shared, two-stage reciprocal-multiply divide-by-9 pipeline.
// Each result is strobed back to the requester that issued it, two edges after it is accepted.
module div9_shared_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_W   = 13,
  parameter logic [15:0] RECIP   = 16'h1C72
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*NUM_W-1:0] req_num,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_W-4:0]         rsp_quot,
  output logic                     rsp_lsb,
  output logic                     busy
);

  localparam int unsigned QW = NUM_W - 3;
  localparam int unsigned TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = NUM_W + 16;

  logic [TW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               s1_v_q, s1_v_d;
  logic [NUM_W-1:0]   s1_num_q, s1_num_d;
  logic [TW-1:0]      s1_tag_q, s1_tag_d;
  logic [NUM_REQ-1:0] s2_vec_q, s2_vec_d;
  logic [QW-1:0]      s2_q_q, s2_q_d;

  logic               found_hi_c;
  logic               found_c;
  logic               accept_c;
  logic [TW-1:0]      gnt_idx_c;
  logic [NUM_W-1:0]   gnt_num_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PW-1:0]      prod_c;

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall
  always_comb begin
    found_hi_c = 1'b0;
    found_c    = 1'b0;
    gnt_c      = '0;
    gnt_idx_c  = '0;
    gnt_num_c  = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found_hi_c && req_valid[i] && (TW'(i) >= rr_ptr_q)) begin
        found_hi_c = 1'b1;
        gnt_c[i]   = 1'b1;
        gnt_idx_c  = TW'(i);
        gnt_num_c  = req_num[i*NUM_W +: NUM_W];
      end
    end
    found_c = found_hi_c;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!found_c && req_valid[i]) begin
        found_c   = 1'b1;
        gnt_c[i]  = 1'b1;
        gnt_idx_c = TW'(i);
        gnt_num_c = req_num[i*NUM_W +: NUM_W];
      end
    end
  end

  assign accept_c  = found_c & ~clr;
  assign req_ready = accept_c ? gnt_c : '0;

  // Q16 reciprocal multiply; the product is wide enough that no bits are lost before the shift
  assign prod_c = PW'(s1_num_q) * PW'(RECIP);

  // Next-state for the pointer and both pipeline stages; clear overrides everything
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    s1_v_d   = accept_c;
    s1_num_d = s1_num_q;
    s1_tag_d = s1_tag_q;
    s2_vec_d = '0;
    s2_q_d   = QW'(prod_c >> 16);

    if (accept_c) begin
      s1_num_d = gnt_num_c;
      s1_tag_d = gnt_idx_c;
      rr_ptr_d = (gnt_idx_c == TW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + TW'(1);
    end

    if (s1_v_q) begin
      s2_vec_d[s1_tag_q] = 1'b1;
    end

    if (clr) begin
      rr_ptr_d = '0;
      s1_v_d   = 1'b0;
      s2_vec_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      s1_v_q   <= 1'b0;
      s1_num_q <= '0;
      s1_tag_q <= '0;
      s2_vec_q <= '0;
      s2_q_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_v_q   <= s1_v_d;
      s1_num_q <= s1_num_d;
      s1_tag_q <= s1_tag_d;
      s2_vec_q <= s2_vec_d;
      s2_q_q   <= s2_q_d;
    end
  end

  // Stage 2 holds the return tag already decoded one-hot, so the strobe comes straight off flops
  assign rsp_valid = s2_vec_q;
  assign rsp_quot  = s2_q_q;
  assign rsp_lsb   = s2_q_q[0];
  assign busy      = s1_v_q | (|s2_vec_q);

endmodule
